mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: 32 shift-add or restoring-divide steps,
// followed by one sign-fix cycle, for a fixed 33-edge latency.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [4:0] LAST_ITER = 5'd31;

    state_t                 state, nextState;
    logic [4:0]             count;
    logic [1:0]             opReg;
    logic [WIDTH-1:0]       aRaw;
    logic [WIDTH-1:0]       aMag;
    logic [WIDTH-1:0]       bMag;
    logic                   negLo;
    logic                   negHi;
    logic                   bZero;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier being consumed / dividend shifting into quotient.
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     accNext;

    logic signed [WIDTH-1:0] aSigned;
    logic signed [WIDTH-1:0] bSigned;
    logic                    aNeg;
    logic                    bNeg;
    logic [WIDTH-1:0]        aMagIn;
    logic [WIDTH-1:0]        bMagIn;

    logic [WIDTH:0]          mulSum;
    logic [WIDTH:0]          divTrial;
    logic [WIDTH:0]          divDiff;

    // Two's-complement negate when the result sign is negative.
    function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] mag,
                                                   input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [2*WIDTH-1:0] applySignWide(input logic [2*WIDTH-1:0] mag,
                                                         input logic neg);
        return neg ? -mag : mag;
    endfunction

    // Signed ops (op[0]=1) work on magnitudes; signs are restored in FIX.
    assign aSigned = operand_a;
    assign bSigned = operand_b;
    assign aNeg    = op[0] && (aSigned < 0);
    assign bNeg    = op[0] && (bSigned < 0);
    assign aMagIn  = aNeg ? -operand_a : operand_a;
    assign bMagIn  = bNeg ? -operand_b : operand_b;

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, aMag} : '0);
        divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff  = divTrial - {1'b0, bMag};
        accNext  = acc;
        if (opReg[1]) begin
            if (!divDiff[WIDTH]) begin
                accNext = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: fixed 32 RUN iterations then one FIX cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (count == 5'd0) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand capture, iteration datapath and result write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            opReg    <= '0;
            aRaw     <= '0;
            aMag     <= '0;
            bMag     <= '0;
            negLo    <= 1'b0;
            negHi    <= 1'b0;
            bZero    <= 1'b0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opReg <= op;
                        aRaw  <= operand_a;
                        aMag  <= aMagIn;
                        bMag  <= bMagIn;
                        negLo <= aNeg ^ bNeg;
                        negHi <= aNeg;
                        bZero <= (operand_b == '0);
                        count <= LAST_ITER;
                        acc   <= op[1] ? {{WIDTH{1'b0}}, aMagIn} : {{WIDTH{1'b0}}, bMagIn};
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    count <= count - 5'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (opReg[1]) begin
                        if (bZero) begin
                            hi       <= aRaw;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi       <= applySign(acc[2*WIDTH-1:WIDTH], negHi);
                            lo       <= applySign(acc[WIDTH-1:0], negLo);
                            div_zero <= 1'b0;
                        end
                    end else begin
                        {hi, lo} <= applySignWide(acc, negLo);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
